fpu_addsub_seq: RTL and testbench
=================================

# fpu_addsub_seq

Sequencing stage directly upstream of the combinational FPU adder/subtractor in the APB FPU. Accepts one single-precision add/sub request through a valid/ready handshake and registers the operands. It drives the adder's operand and select inputs for a programmable settle window, then captures the combinational result into a held response register. It also bypasses zero/denormal operands, which the adder cannot handle because it always inserts a hidden 1.

## Interface
Parameters:
- SETTLE_CYCLES, 1, cycles the adder selects stay asserted before capture (multicycle path budget); legal range 1..15
- CNT_W, 16, width of completed-operation counter

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op1  in  32  IEEE-754 single operand 1
- req_op2  in  32  IEEE-754 single operand 2
- req_sub  in  1  0 = op1+op2, 1 = op1-op2
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer takes response
- rsp_result  out  32  result word
- rsp_flags  out  2  bit0 = bypass used, bit1 = adder valid missing at capture
- fpu_op1  out  32  to adder OP1
- fpu_op2  out  32  to adder OP2
- fpu_add_select  out  1  to adder add_select
- fpu_sub_select  out  1  to adder sub_select
- fpu_result  in  32  from adder Result_comb
- fpu_valid  in  1  from adder valid
- op_count  out  CNT_W  responses completed, wraps

## Operation
- FSM states: IDLE, SETTLE, RESP.
- `req_ready = (state == IDLE)`. This is combinational, so it reads 1 during and after reset.
- IDLE: when `req_valid & req_ready`, latch op1, op2 and sub into `fpu_op1`/`fpu_op2`/sub register.
  - If either exponent field [30:23] == 0, the request is a bypass case. Load `rsp_result` and flags, then go to RESP.
  - Otherwise load the settle counter with `SETTLE_CYCLES-1` and go to SETTLE.
- Bypass results (zero or denormal is treated as zero):
  - op2 zero: result = op1.
  - op1 zero, op2 nonzero: result = op2 for add; {~op2[31], op2[30:0]} for sub.
  - Both zero: result = 0x00000000, except for add with both signs 1, which gives 0x80000000.
  - `rsp_flags` = 2'b01.
- SETTLE:
  - `fpu_add_select = ~sub`, `fpu_sub_select = sub`. Both selects are 0 in every other state.
  - Counter decrements each cycle. At count 0, capture and go to RESP.
  - Capture with `fpu_valid = 1`: `rsp_result = fpu_result`, flags = 2'b00.
  - Capture with `fpu_valid = 0`: `rsp_result = 0`, flags = 2'b10.
- RESP:
  - `rsp_valid = 1`.
  - `rsp_result`/`rsp_flags` are held stable until `rsp_valid & rsp_ready`. Then return to IDLE and increment `op_count`, wrapping 2^CNT_W-1 → 0.
- `fpu_op1`/`fpu_op2` keep their last values outside SETTLE. No new request is latched until IDLE.
- No rounding, NaN or Inf handling; the adder's result passes through unmodified.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE
  - rsp_valid = 0
  - rsp_result = 0
  - rsp_flags = 0
  - fpu_op1 = fpu_op2 = 0
  - both selects = 0
  - op_count = 0
- Latency, with the request accepted in cycle T:
  - Normal path: selects high in cycles T+1 .. T+SETTLE_CYCLES; capture on the clock edge ending T+SETTLE_CYCLES; `rsp_valid` high from T+SETTLE_CYCLES+1.
  - Bypass path: `rsp_valid` high from T+1; selects never asserted.
- Throughput:
  - The response handshake in cycle R returns the FSM to IDLE in R+1, which is the earliest next accept.
  - No back-to-back operation: one op per SETTLE_CYCLES+2 cycles minimum.
- Backpressure: while `rsp_ready = 0` the response holds indefinitely, `req_ready = 0`, and upstream must keep its request stable.
- Reset mid-operation (SETTLE or RESP): the operation is discarded, outputs return to reset values at once, and no count increment occurs.
- `req_valid` asserted while in SETTLE/RESP is ignored (not latched).

## Test plan
- Add, SETTLE_CYCLES = 1: op1 0x3F800000 + op2 0x40000000. Required:
  - `fpu_add_select` high in T+1 only.
  - `rsp_result` 0x40400000 with flags 00, `rsp_valid` at T+2.
  - `op_count` 1 after the handshake.
- Sub, SETTLE_CYCLES = 3: 0x40400000 - 0x3F800000. Required:
  - `fpu_sub_select` high in T+1..T+3.
  - `rsp_result` 0x40000000, `rsp_valid` at T+4.
- Bypass cases, each with `rsp_valid` at T+1, selects never high, flags 01:
  - 0x00000000 + 0xC0A00000 → 0xC0A00000.
  - 0x00000000 - 0x40400000 → 0xC0400000.
  - 0x80000000 + 0x80000000 → 0x80000000.
- Backpressure: hold `rsp_ready = 0` for 5 cycles with a second request pending. Required:
  - Result is stable and `req_ready` stays 0.
  - The second request is accepted the cycle after the handshake.
- Fault and reset:
  - Force `fpu_valid = 0` during SETTLE: `rsp_result` 0 with flags 10.
  - Assert `rstn` low mid-SETTLE: `rsp_valid`, selects and `op_count` go to 0 immediately; FSM is in IDLE after release.
- Counter wrap, CNT_W = 4: after 16 completed operations `op_count` = 0; after the 17th it reads 1.

Source files
------------

// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: one-request sequencer around a combinational single-precision adder.
// It holds the operands through a settle window and bypasses zero/denormal operands.
module fpu_addsub_seq #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_op1,
  input  logic [31:0]      req_op2,
  input  logic             req_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [1:0]       rsp_flags,
  output logic [31:0]      fpu_op1,
  output logic [31:0]      fpu_op2,
  output logic             fpu_add_select,
  output logic             fpu_sub_select,
  input  logic [31:0]      fpu_result,
  input  logic             fpu_valid,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  state_t state, state_n;
  logic sub_q, acc, z1, z2, capture;
  logic [3:0] cnt;
  logic [31:0] byp_result;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign acc = req_valid & req_ready;
  assign capture = state == SETTLE && cnt == 4'd0;
  assign fpu_add_select = state == SETTLE && !sub_q;
  assign fpu_sub_select = state == SETTLE && sub_q;
  // Denormals count as zero: the adder would wrongly add a hidden 1 to them.
  assign z1 = ~|req_op1[30:23];
  assign z2 = ~|req_op2[30:23];
  assign byp_result = (z1 && z2) ? {!req_sub & req_op1[31] & req_op2[31], 31'b0} :
                      z2 ? req_op1 : {req_sub ^ req_op2[31], req_op2[30:0]};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = acc ? ((z1 || z2) ? RESP : SETTLE) : IDLE;
      SETTLE:  state_n = capture ? RESP : SETTLE;
      RESP:    state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      sub_q      <= 1'b0;
      cnt        <= 4'd0;
      fpu_op1    <= '0;
      fpu_op2    <= '0;
      rsp_result <= '0;
      rsp_flags  <= 2'b00;
      op_count   <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        fpu_op1 <= req_op1;
        fpu_op2 <= req_op2;
        sub_q   <= req_sub;
        cnt     <= CNT_INIT;
        if (z1 || z2) begin
          rsp_result <= byp_result;
          rsp_flags  <= 2'b01;
        end
      end
      if (state == SETTLE) cnt <= cnt - 4'd1;
      if (capture) begin
        rsp_result <= fpu_valid ? fpu_result : '0;
        rsp_flags  <= fpu_valid ? 2'b00 : 2'b10;
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb_fpu_addsub_seq: directed vectors with a queue scoreboard; a stand-in adder answers
// only the hand-computed operand pairs and raises valid while a select is high.
module tb_fpu_addsub_seq;
  localparam int SETTLE = 3;
  typedef struct packed {logic [31:0] res; logic [1:0] flg;} exp_t;
  logic clk = 0, rstn = 1, force_inv = 0;
  logic req_valid = 0, req_sub = 0, rsp_ready = 1;
  logic [31:0] req_op1 = 0, req_op2 = 0;
  logic req_ready, rsp_valid, fpu_add_select, fpu_sub_select, fpu_valid;
  logic [31:0] rsp_result, fpu_op1, fpu_op2, fpu_result;
  logic [1:0] rsp_flags;
  logic [3:0] op_count, exp_cnt = 0;
  logic s1_valid = 0, s1_sub = 0, s1_rready = 1;
  logic [31:0] s1_op1 = 0, s1_op2 = 0;
  logic s1_ready, s1_rvalid, s1_add, s1_subsel, s1_fvalid;
  logic [31:0] s1_result, s1_fop1, s1_fop2, s1_fres;
  logic [1:0] s1_flags;
  logic [15:0] s1_count;
  exp_t sb[$];
  int applied = 0, checks = 0, fails = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] adder_model(input logic [31:0] a, b, input logic s);
    case ({a, b, s})
      {32'h3F800000, 32'h40000000, 1'b0}: return 32'h40400000;
      {32'h40400000, 32'h3F800000, 1'b1}: return 32'h40000000;
      {32'h40A00000, 32'h3F800000, 1'b0}: return 32'h40C00000;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign fpu_result = adder_model(fpu_op1, fpu_op2, fpu_sub_select);
  assign fpu_valid  = (fpu_add_select | fpu_sub_select) & ~force_inv;
  assign s1_fres    = adder_model(s1_fop1, s1_fop2, s1_subsel);
  assign s1_fvalid  = s1_add | s1_subsel;

  fpu_addsub_seq #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) u_dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .fpu_op1(fpu_op1), .fpu_op2(fpu_op2), .fpu_add_select(fpu_add_select),
    .fpu_sub_select(fpu_sub_select), .fpu_result(fpu_result), .fpu_valid(fpu_valid),
    .op_count(op_count));

  fpu_addsub_seq #(.SETTLE_CYCLES(1), .CNT_W(16)) u_s1 (
    .clk(clk), .rstn(rstn), .req_valid(s1_valid), .req_ready(s1_ready),
    .req_op1(s1_op1), .req_op2(s1_op2), .req_sub(s1_sub),
    .rsp_valid(s1_rvalid), .rsp_ready(s1_rready), .rsp_result(s1_result), .rsp_flags(s1_flags),
    .fpu_op1(s1_fop1), .fpu_op2(s1_fop2), .fpu_add_select(s1_add),
    .fpu_sub_select(s1_subsel), .fpu_result(s1_fres), .fpu_valid(s1_fvalid),
    .op_count(s1_count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_rsp: got %h with nothing expected", rsp_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_flags", {30'b0, rsp_flags}, {30'b0, e.flg});
      end
    end
  end

  task automatic issue(input logic [31:0] a, b, input logic s, input logic [31:0] er, input logic [1:0] ef);
    int n;
    n = 0;
    req_op1 = a; req_op2 = b; req_sub = s; req_valid = 1;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept_wait", n < 50, 1);
    sb.push_back('{er, ef});
    applied++;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic run_op(input logic [31:0] a, b, input logic s, input logic [31:0] er, input logic [1:0] ef, input bit byp);
    int k, na, ns;
    issue(a, b, s, er, ef);
    k = 1; na = 0; ns = 0;
    while (!rsp_valid && k < 40) begin
      na += int'(fpu_add_select);
      ns += int'(fpu_sub_select);
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, byp ? 1 : SETTLE + 1);
    chk("add_sel_cycles", na, (byp || s) ? 0 : SETTLE);
    chk("sub_sel_cycles", ns, (byp || !s) ? 0 : SETTLE);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 4'd1;
    chk("op_count", {28'b0, op_count}, {28'b0, exp_cnt});
    chk("req_ready_idle", req_ready, 1);
  endtask

  initial begin
    int n;
    #1 rstn = 0;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", {30'b0, rsp_flags}, 0);
    chk("rst_fpu_op1", fpu_op1, 0);
    chk("rst_sel", {fpu_add_select, fpu_sub_select}, 0);
    chk("rst_op_count", {28'b0, op_count}, 0);
    @(negedge clk) rstn = 1;
    @(posedge clk); #1;
    s1_op1 = 32'h3F800000; s1_op2 = 32'h40000000; s1_sub = 0; s1_valid = 1;
    @(posedge clk); #1;
    s1_valid = 0;
    applied++;
    chk("s1_add_sel_t1", s1_add, 1);
    chk("s1_rvalid_t1", s1_rvalid, 0);
    @(posedge clk); #1;
    chk("s1_add_sel_t2", s1_add, 0);
    chk("s1_rvalid_t2", s1_rvalid, 1);
    chk("s1_result", s1_result, 32'h40400000);
    chk("s1_flags", {30'b0, s1_flags}, 0);
    @(posedge clk); #1;
    chk("s1_op_count", {16'b0, s1_count}, 1);
    chk("s1_ready_after", s1_ready, 1);
    run_op(32'h40400000, 32'h3F800000, 1, 32'h40000000, 2'b00, 0);
    run_op(32'h3F800000, 32'h40000000, 0, 32'h40400000, 2'b00, 0);
    run_op(32'h00000000, 32'hC0A00000, 0, 32'hC0A00000, 2'b01, 1);
    run_op(32'h00000000, 32'h40400000, 1, 32'hC0400000, 2'b01, 1);
    run_op(32'h80000000, 32'h80000000, 0, 32'h80000000, 2'b01, 1);
    run_op(32'h80000000, 32'h80000000, 1, 32'h00000000, 2'b01, 1);
    run_op(32'h80000000, 32'h00000000, 0, 32'h00000000, 2'b01, 1);
    run_op(32'h3F800000, 32'h00400000, 1, 32'h3F800000, 2'b01, 1);
    run_op(32'h00400000, 32'hC0A00000, 1, 32'h40A00000, 2'b01, 1);
    force_inv = 1;
    run_op(32'h3F800000, 32'h40000000, 0, 32'h00000000, 2'b10, 0);
    force_inv = 0;
    rsp_ready = 0;
    issue(32'h40A00000, 32'h3F800000, 0, 32'h40C00000, 2'b00);
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("bp_latency", n, SETTLE);
    sb.push_back('{32'hC0A00000, 2'b01});
    applied++;
    req_op1 = 0; req_op2 = 32'hC0A00000; req_sub = 0; req_valid = 1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_result", rsp_result, 32'h40C00000);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 4'd1;
    chk("bp_accept_ready", req_ready, 1);
    chk("bp_op_count1", {28'b0, op_count}, {28'b0, exp_cnt});
    @(posedge clk); #1;
    req_valid = 0;
    chk("bp_second_valid", rsp_valid, 1);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 4'd1;
    chk("bp_op_count2", {28'b0, op_count}, {28'b0, exp_cnt});
    issue(32'h3F800000, 32'h40000000, 0, 32'h40400000, 2'b00);
    sb.delete();
    applied--;
    @(posedge clk); #2;
    rstn = 0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_sel", {fpu_add_select, fpu_sub_select}, 0);
    chk("mid_rst_op_count", {28'b0, op_count}, 0);
    chk("mid_rst_fpu_op1", fpu_op1, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    exp_cnt = 0;
    @(negedge clk) rstn = 1;
    @(posedge clk); #1;
    chk("post_rst_idle", {req_ready, rsp_valid}, 2'b10);
    for (int i = 0; i < 17; i++) begin
      logic [31:0] a;
      a = 32'h3F800000 + (i << 12);
      run_op(a, 32'h00000000, i[0], a, 2'b01, 1);
      if (i == 15) chk("wrap_zero", {28'b0, op_count}, 0);
    end
    chk("wrap_one", {28'b0, op_count}, 1);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish after %0d checks", checks);
    $fatal(1, "timeout");
  end
endmodule
